// File: rtl/optical_flow_div_36s_18s_18_seq.sv
`default_nettype none
// ============================================================================
// optical_flow_div_36s_18s_18_seq: radix-2 restoring signed divider, 36s/18s,
// saturated 18-bit quotient and remainder, valid/ready handshake at both ends.
// Revision: 1.0
// ============================================================================
module optical_flow_div_36s_18s_18_seq #(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 36,
  parameter int DIVISOR_WIDTH  = 18,
  parameter int QUOTIENT_WIDTH = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int c_dw = DIVIDEND_WIDTH;
  localparam int c_sw = DIVISOR_WIDTH;
  localparam int c_qw = QUOTIENT_WIDTH;
  localparam int c_cw = $clog2(c_dw);

  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(c_dw - 1);
  localparam logic [c_dw-1:0] c_qpos_mag = {{(c_dw-c_qw+1){1'b0}}, {(c_qw-1){1'b1}}};
  localparam logic [c_dw-1:0] c_qneg_mag = c_qpos_mag + 1'b1;
  localparam logic [c_qw-1:0] c_qmax     = {1'b0, {(c_qw-1){1'b1}}};
  localparam logic [c_qw-1:0] c_qmin     = {1'b1, {(c_qw-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic [c_dw-1:0]   r_dvd;
  logic [c_dw-1:0]   r_quo;
  logic [c_sw-1:0]   r_dvs;
  logic [c_sw-1:0]   r_rem;
  logic [c_sw-1:0]   r_dvd_lo;
  logic              r_sa;
  logic              r_sb;
  logic              r_dbz;

  logic [c_dw-1:0]   w_dvd_mag;
  logic [c_sw-1:0]   w_dvs_mag;
  logic [c_sw:0]     w_shift;
  logic [c_sw-1:0]   w_sub;
  logic              w_ge;
  logic [c_sw-1:0]   w_rem_next;
  logic              w_neg;
  logic              w_q_clip;
  logic [c_qw-1:0]   w_q_low;
  logic [c_qw-1:0]   w_q_signed;
  logic [c_sw-1:0]   w_r_signed;

  // Two's-complement magnitude: the most negative value maps onto its
  // unsigned magnitude without overflow because the result is unsigned.
  assign w_dvd_mag = dividend[c_dw-1] ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = divisor[c_sw-1]  ? (~divisor + 1'b1)  : divisor;

  assign w_shift    = {r_rem, r_dvd[r_cnt]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  // The difference is below |divisor| whenever it is kept, so it fits c_sw bits.
  assign w_sub      = w_shift[c_sw-1:0] - r_dvs;
  assign w_rem_next = w_ge ? w_sub : w_shift[c_sw-1:0];

  assign w_neg      = r_sa ^ r_sb;
  assign w_q_clip   = w_neg ? (r_quo > c_qneg_mag) : (r_quo > c_qpos_mag);
  assign w_q_low    = r_quo[c_qw-1:0];
  assign w_q_signed = w_neg ? (~w_q_low + 1'b1) : w_q_low;
  assign w_r_signed = r_sa ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_dvd_lo  <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_dvd_lo <= dividend[c_sw-1:0];
            r_sa     <= dividend[c_dw-1];
            r_sb     <= divisor[c_sw-1];
            r_dbz    <= (divisor == '0);
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= c_cnt_init;
            in_ready <= 1'b0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem        <= w_rem_next;
          r_quo[r_cnt] <= w_ge;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (r_dbz) begin
            quotient  <= r_sa ? c_qmin : c_qmax;
            remainder <= r_dvd_lo;
            ovf       <= 1'b1;
            dbz       <= 1'b1;
          end else begin
            quotient  <= w_q_clip ? (w_neg ? c_qmin : c_qmax) : w_q_signed;
            remainder <= w_r_signed;
            ovf       <= w_q_clip;
            dbz       <= 1'b0;
          end
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // Ready is raised only after leaving DONE, so no accept overlaps
          // the result handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
